// File: rtl/ex_muldiv_stage.sv
// Execute stage: ID/EX pipeline register, HI/LO registers and a multi-cycle multiply/divide engine.
// Optional build macro MUL_FAST_EN: single-step multiply that raises no stall request.
module ex_muldiv_stage #(
    parameter int DATA_W    = 32,
    parameter int MUL_LAT   = 3,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [STALL_W-1:0]  stall,
    input  logic                id_valid,
    input  logic [31:0]         id_pc,
    input  logic [3:0]          id_op,
    input  logic [DATA_W-1:0]   id_alu_res,
    input  logic [DATA_W-1:0]   id_src1,
    input  logic [DATA_W-1:0]   id_src2,
    input  logic                id_rf_we,
    input  logic [4:0]          id_rf_waddr,
    output logic                ex_valid,
    output logic [31:0]         ex_pc,
    output logic                ex_rf_we,
    output logic [4:0]          ex_rf_waddr,
    output logic [DATA_W-1:0]   ex_result,
    output logic                stallreq,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo
);
    localparam logic [3:0] OP_ALU = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                           OP_DIVU = 4'd4, OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7,
                           OP_MTLO = 4'd8;
    localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    logic                ex_valid_q, ex_rf_we_q;
    logic [31:0]         ex_pc_q;
    logic [3:0]          ex_op_q;
    logic [4:0]          ex_rf_waddr_q;
    logic [DATA_W-1:0]   ex_alu_res_q, ex_src1_q, ex_src2_q;

    logic stall_here, stall_next, load_bubble, load_instr, capture, retire;
    logic unused_stall_bits;

    assign stall_here        = stall[STAGE_IDX];
    assign stall_next        = stall[STAGE_IDX+1];
    assign load_bubble       = stall_here && !stall_next;
    assign load_instr        = !stall_here;
    assign capture           = load_bubble || load_instr;
    assign retire            = ex_valid_q && !stall_next;
    assign unused_stall_bits = ^stall;

    always_ff @(posedge clk) begin
        if (rst || flush || load_bubble) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_op_q       <= OP_ALU;
            ex_alu_res_q  <= '0;
            ex_src1_q     <= '0;
            ex_src2_q     <= '0;
            ex_rf_we_q    <= 1'b0;
            ex_rf_waddr_q <= '0;
        end else if (load_instr) begin
            ex_valid_q    <= id_valid;
            ex_pc_q       <= id_pc;
            ex_op_q       <= id_op;
            ex_alu_res_q  <= id_alu_res;
            ex_src1_q     <= id_src1;
            ex_src2_q     <= id_src2;
            ex_rf_we_q    <= id_rf_we;
            ex_rf_waddr_q <= id_rf_waddr;
        end
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic                is_div_q, is_div_d, quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
    logic                dz_q, dz_d, done_q, done_d;

    logic                is_mul_op, is_div_op, op_signed, neg1, neg2, launch_mul, launch_div, fits;
    logic [DATA_W-1:0]   mag1, mag2, quo_fix, rem_fix;
    logic [2*DATA_W-1:0] mag_prod, mul_prod;
    logic [DATA_W:0]     rem_shift, rem_diff;

    assign is_mul_op  = ex_valid_q && (ex_op_q == OP_MULT || ex_op_q == OP_MULTU);
    assign is_div_op  = ex_valid_q && (ex_op_q == OP_DIV  || ex_op_q == OP_DIVU);
    assign op_signed  = (ex_op_q == OP_MULT) || (ex_op_q == OP_DIV);
    assign neg1       = op_signed && ex_src1_q[DATA_W-1];
    assign neg2       = op_signed && ex_src2_q[DATA_W-1];
    assign mag1       = neg1 ? -ex_src1_q : ex_src1_q;
    assign mag2       = neg2 ? -ex_src2_q : ex_src2_q;
    // done_q blocks a relaunch while a finished op is still held in the register
    assign launch_mul = is_mul_op && !done_q;
    assign launch_div = is_div_op && !done_q;

    assign mag_prod  = {{DATA_W{1'b0}}, mag1} * {{DATA_W{1'b0}}, mag2};
    assign mul_prod  = (neg1 ^ neg2) ? -mag_prod : mag_prod;
    assign rem_shift = {rem_q, quo_q[DATA_W-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign fits      = !rem_diff[DATA_W];
    assign quo_fix   = quo_neg_q ? -quo_q : quo_q;
    assign rem_fix   = rem_neg_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        prod_d    = prod_q;
        is_div_d  = is_div_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        done_d    = done_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (launch_mul) begin
                    prod_d   = mul_prod;
                    is_div_d = 1'b0;
                    cnt_d    = CNT_W'(MUL_LAT - 1);
`ifdef MUL_FAST_EN
                    state_d  = S_DONE;
`else
                    state_d  = (MUL_LAT <= 1) ? S_DONE : S_MUL;
`endif
                end else if (launch_div) begin
                    is_div_d  = 1'b1;
                    rem_d     = '0;
                    quo_d     = mag1;
                    dvs_d     = mag2;
                    dvd_d     = ex_src1_q;
                    dz_d      = (ex_src2_q == '0);
                    quo_neg_d = neg1 ^ neg2;
                    rem_neg_d = neg1;
                    cnt_d     = CNT_W'(DATA_W);
                    state_d   = S_DIV;
                end
            end
            S_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = S_DONE;
            end
            S_DIV: begin
                quo_d = {quo_q[DATA_W-2:0], fits};
                rem_d = fits ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!flush) begin
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_q;
                    end else if (dz_q) begin
                        hi_d = dvd_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (retire && ex_op_q == OP_MTHI) hi_d = ex_src1_q;
        if (retire && ex_op_q == OP_MTLO) lo_d = ex_src1_q;
        if (capture || flush) done_d = 1'b0;
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_q     <= '0;
            prod_q    <= '0;
            is_div_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            dvd_q     <= dvd_d;
            prod_q    <= prod_d;
            is_div_q  <= is_div_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

`ifdef MUL_FAST_EN
    assign stallreq = ((state_q == S_IDLE) && launch_div) || (state_q == S_DIV);
`else
    assign stallreq = ((state_q == S_IDLE) && (launch_div || launch_mul))
                    || (state_q == S_MUL) || (state_q == S_DIV);
`endif

    always_comb begin
        ex_result = '0;
        case (ex_op_q)
            OP_ALU:  ex_result = ex_alu_res_q;
            OP_MFHI: ex_result = hi_q;
            OP_MFLO: ex_result = lo_q;
            default: ex_result = '0;
        endcase
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rf_we    = ex_rf_we_q;
    assign ex_rf_waddr = ex_rf_waddr_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Self-checking bench for ex_muldiv_stage: directed cases plus random MUL/DIV against an arithmetic model.
module tb_ex_muldiv_stage;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [5:0]  ext_stall, stall;
    logic        id_valid, id_rf_we;
    logic [31:0] id_pc, id_alu_res, id_src1, id_src2;
    logic [3:0]  id_op;
    logic [4:0]  id_rf_waddr;
    logic        ex_valid, ex_rf_we, stallreq;
    logic [31:0] ex_pc, ex_result, hi, lo;
    logic [4:0]  ex_rf_waddr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    always #5 clk = ~clk;

    // Controller model: a busy engine freezes every stage up to and including this one.
    assign stall = ext_stall | (stallreq ? 6'b001111 : 6'b000000);

    ex_muldiv_stage #(.DATA_W(32), .MUL_LAT(MUL_LAT), .STALL_W(6), .STAGE_IDX(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_op(id_op), .id_alu_res(id_alu_res),
        .id_src1(id_src1), .id_src2(id_src2), .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_result(ex_result), .stallreq(stallreq), .hi(hi), .lo(lo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] alu, input logic we, input logic [4:0] wa);
        pc_ctr      = pc_ctr + 32'd4;
        id_valid    = 1'b1;
        id_pc       = pc_ctr;
        id_op       = op;
        id_src1     = s1;
        id_src2     = s2;
        id_alu_res  = alu;
        id_rf_we    = we;
        id_rf_waddr = wa;
    endtask

    task automatic idle_id();
        id_valid = 1'b0; id_pc = '0; id_op = '0; id_src1 = '0;
        id_src2 = '0; id_alu_res = '0; id_rf_we = 1'b0; id_rf_waddr = '0;
    endtask

    // Architectural result {HI, LO} straight from the arithmetic definition.
    function automatic logic [63:0] ref_muldiv(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sq, sr;
        case (op)
            4'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
            4'd2: begin up = longint'(a) * longint'(b); return up; end
            4'd3: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            4'd4: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic run_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int hold, input string tag);
        logic [63:0] exp;
        int          lat, cyc;
        exp = ref_muldiv(op, a, b);
        lat = (op == 4'd3 || op == 4'd4) ? 33 : MUL_LAT;
`ifdef MUL_FAST_EN
        if (op == 4'd1 || op == 4'd2) lat = 0;
`endif
        set_id(op, a, b, 32'h0, 1'b0, 5'd0);
        step();
        idle_id();
        chk({tag, "/valid"}, ex_valid, 1);
        cyc = 0;
        while (stallreq === 1'b1 && cyc < 100) begin
            cyc++;
            step();
        end
        chk({tag, "/stall_cycles"}, cyc, lat);
        if (lat == 0) step();
        if (hold > 0) ext_stall = 6'b001111;
        step();
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        chk({tag, "/hi"}, hi, m_hi);
        chk({tag, "/lo"}, lo, m_lo);
        for (int i = 0; i < hold; i++) begin
            chk($sformatf("%s/hold%0d_stallreq", tag, i), stallreq, 0);
            chk($sformatf("%s/hold%0d_valid", tag, i), ex_valid, 1);
            chk($sformatf("%s/hold%0d_hi", tag, i), hi, m_hi);
            step();
        end
        ext_stall = 6'b0;
        $display("%s op=%0d src1=%h src2=%h stall_cycles=%0d hi=%h lo=%h", tag, op, a, b, cyc, hi, lo);
    endtask

    task automatic read_hilo(input logic [3:0] op, input string tag);
        set_id(op, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
        step();
        idle_id();
        chk(tag, ex_result, (op == 4'd5) ? m_hi : m_lo);
        $display("%s op=%0d ex_result=%h", tag, op, ex_result);
    endtask

    initial begin
        logic [31:0] prev_hi, prev_lo, ra, rb, alu;
        logic [3:0]  rop;
        int          cyc;

        rst = 1'b1; flush = 1'b0; ext_stall = 6'b0;
        idle_id();
        step(); step();
        chk("reset/ex_valid", ex_valid, 0);
        chk("reset/ex_result", ex_result, 0);
        chk("reset/ex_rf_we", ex_rf_we, 0);
        chk("reset/stallreq", stallreq, 0);
        chk("reset/hi", hi, 0);
        chk("reset/lo", lo, 0);
        rst = 1'b0;
        step();

        alu = $urandom;
        set_id(4'd0, 32'h0, 32'h0, alu, 1'b1, 5'd3);
        step();
        chk("alu/result", ex_result, alu);
        chk("alu/pc", ex_pc, pc_ctr);
        chk("alu/rf_we", ex_rf_we, 1);
        chk("alu/waddr", ex_rf_waddr, 3);
        chk("alu/stallreq", stallreq, 0);
        $display("alu pass alu_res=%h ex_result=%h", alu, ex_result);
        idle_id();
        step();

        run_muldiv(4'd2, 32'hFFFF_FFFF, 32'd2, 0, "multu_max");
        read_hilo(4'd6, "mflo_after_multu");
        run_muldiv(4'd1, 32'hFFFF_FFF9, 32'd6, 0, "mult_neg");
        run_muldiv(4'd3, 32'hFFFF_FFF9, 32'd2, 0, "div_neg7_2");
        run_muldiv(4'd4, 32'd5, 32'd0, 0, "divu_by_zero");
        run_muldiv(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
        run_muldiv(4'd3, 32'd100, 32'hFFFF_FFF9, 4, "div_held");
        read_hilo(4'd5, "mfhi_after_held");

        prev_hi = m_hi;
        prev_lo = m_lo;
        set_id(4'd3, 32'd1000, 32'd3, 32'h0, 1'b0, 5'd0);
        step();
        idle_id();
        cyc = 0;
        while (stallreq === 1'b1 && cyc < 10) begin
            cyc++;
            step();
        end
        chk("flush/busy_before", cyc, 10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush/stallreq", stallreq, 0);
        chk("flush/ex_valid", ex_valid, 0);
        chk("flush/hi", hi, prev_hi);
        chk("flush/lo", lo, prev_lo);
        repeat (40) step();
        chk("flush/hi_later", hi, prev_hi);
        chk("flush/stallreq_later", stallreq, 0);
        $display("flush mid-div hi=%h lo=%h", hi, lo);

        set_id(4'd7, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 5'd0);
        step();
        set_id(4'd5, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9);
        step();
        m_hi = 32'h1234_5678;
        chk("mthi_mfhi/result", ex_result, m_hi);
        chk("mthi_mfhi/hi", hi, m_hi);
        chk("mthi_mfhi/rf_we", ex_rf_we, 1);
        $display("mthi then mfhi ex_result=%h", ex_result);
        ext_stall = 6'b000111;
        step();
        ext_stall = 6'b0;
        chk("bubble/ex_valid", ex_valid, 0);
        chk("bubble/rf_we", ex_rf_we, 0);
        chk("bubble/result", ex_result, 0);
        $display("bubble ex_valid=%0d ex_rf_we=%0d", ex_valid, ex_rf_we);
        idle_id();
        set_id(4'd8, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 5'd0);
        step();
        idle_id();
        step();
        m_lo = 32'hCAFE_F00D;
        read_hilo(4'd6, "mtlo_mflo");

        for (int n = 0; n < 12; n++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_muldiv(rop, ra, rb, 0, $sformatf("rand%0d", n));
            read_hilo(4'd5, $sformatf("rand%0d/mfhi", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
